multi_channel_tick_generator: RTL and testbench



---
 rtl/tick_gen_pkg.sv | 16 +
 rtl/multi_channel_tick_generator_channel.sv | 70 +++++++
 rtl/multi_channel_tick_generator.sv | 48 ++++
 tb/tb_multi_channel_tick_generator.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// Shared clock-rate constants and divisor helper for the tick generator slice.
// All rates are derived from the 100 MHz board clock.
package tick_gen_pkg;

    localparam int unsigned CLK_FREQ_HZ = 100_000_000;

    // Divisor that gives a square wave of freq_hz; the tick rate is twice that.
    function automatic int unsigned hz_to_div(input int unsigned freq_hz);
        return CLK_FREQ_HZ / (2 * freq_hz);
    endfunction

    localparam int unsigned DIV_1HZ           = 50_000_000;
    localparam int unsigned DIV_1KHZ          = 50_000;
    localparam int unsigned DIV_REFRESH_10KHZ = 5_000;

endpackage : tick_gen_pkg

// File: rtl/multi_channel_tick_generator_channel.sv
// One rate channel: a divisor register, an up-counter, a one-cycle tick strobe and
// a square wave that toggles on every tick.
module tick_channel #(
    parameter int unsigned CNT_W     = 27,
    parameter int unsigned DIV_RESET = 50_000_000
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             enable,
    input  logic             clr,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_val,
    output logic             tick,
    output logic             sq_out
);

    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic [CNT_W-1:0] wr_eff;
    logic             at_terminal;

    // A zero divisor is meaningless, so it is stored as 1 (tick every cycle).
    assign wr_eff      = (wr_val == '0) ? CNT_W'(1) : wr_val;
    assign at_terminal = (cnt_q == div_q - CNT_W'(1));

    always_comb begin
        div_d  = div_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        sq_d   = sq_q;
        if (clr) begin
            if (wr) begin
                div_d = wr_eff;
            end
            cnt_d = '0;
            sq_d  = 1'b0;
        end else if (wr) begin
            div_d = wr_eff;
            cnt_d = '0;
        end else if (enable) begin
            if (at_terminal) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                sq_d   = ~sq_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            div_q  <= CNT_W'(DIV_RESET);
            cnt_q  <= '0;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    assign tick   = tick_q;
    assign sq_out = sq_q;

endmodule : tick_channel

// File: rtl/multi_channel_tick_generator.sv
// NUM_CH independent programmable tick/square-wave channels in the clk_100MHz domain.
// Outputs are clock enables for downstream logic, never derived clocks.
module multi_channel_tick_generator
    import tick_gen_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CNT_W     = 27,
    parameter int unsigned DIV_RESET = DIV_1HZ,
    parameter int unsigned SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    input  logic              enable,
    input  logic              sync_clr,
    input  logic              div_wr,
    input  logic [SEL_W-1:0]  div_sel,
    input  logic [CNT_W-1:0]  div_val,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq_out
);

    logic [NUM_CH-1:0] wr_sel;

    // Out-of-range selects match no channel, so such writes are dropped.
    always_comb begin
        wr_sel = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            wr_sel[i] = div_wr && (div_sel == SEL_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tick_channel #(
            .CNT_W     (CNT_W),
            .DIV_RESET (DIV_RESET)
        ) u_ch (
            .clk_100MHz (clk_100MHz),
            .reset      (reset),
            .enable     (enable),
            .clr        (sync_clr),
            .wr         (wr_sel[g]),
            .wr_val     (div_val),
            .tick       (tick[g]),
            .sq_out     (sq_out[g])
        );
    end

endmodule : multi_channel_tick_generator

// File: tb/tb_multi_channel_tick_generator.sv
// Scoreboard bench: a countdown reference model pushes expected outputs per cycle,
// which are popped and compared on the following falling edge.
module tb_multi_channel_tick_generator;

    localparam int unsigned NCH   = 4;
    localparam int unsigned CW    = 27;
    localparam int unsigned DIVR  = 10;
    localparam int unsigned SW    = 3;

    logic              clk_100MHz = 1'b0;
    logic              reset      = 1'b1;
    logic              enable     = 1'b0;
    logic              sync_clr   = 1'b0;
    logic              div_wr     = 1'b0;
    logic [SW-1:0]     div_sel    = '0;
    logic [CW-1:0]     div_val    = '0;
    logic [NCH-1:0]    tick;
    logic [NCH-1:0]    sq_out;

    multi_channel_tick_generator #(
        .NUM_CH    (NCH),
        .CNT_W     (CW),
        .DIV_RESET (DIVR),
        .SEL_W     (SW)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .enable     (enable),
        .sync_clr   (sync_clr),
        .div_wr     (div_wr),
        .div_sel    (div_sel),
        .div_val    (div_val),
        .tick       (tick),
        .sq_out     (sq_out)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    typedef struct packed {
        logic [NCH-1:0] tick;
        logic [NCH-1:0] sq;
    } exp_t;

    exp_t           exp_q[$];
    int unsigned    m_div [NCH];
    int unsigned    m_rem [NCH];
    logic [NCH-1:0] m_tick;
    logic [NCH-1:0] m_sq;
    int unsigned    hits [NCH];
    int unsigned    n_checks = 0;
    int unsigned    n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    endtask

    // Reference model counts down the cycles remaining until the next tick.
    task automatic model_step();
        exp_t e;
        for (int ch = 0; ch < NCH; ch++) begin
            logic hit;
            int unsigned eff;
            hit = div_wr && (int'(div_sel) == ch);
            eff = (div_val == '0) ? 1 : int'(div_val);
            if (reset) begin
                m_div[ch] = DIVR; m_rem[ch] = DIVR; m_tick[ch] = 1'b0; m_sq[ch] = 1'b0;
            end else if (sync_clr) begin
                if (hit) m_div[ch] = eff;
                m_rem[ch] = m_div[ch]; m_tick[ch] = 1'b0; m_sq[ch] = 1'b0;
            end else if (hit) begin
                m_div[ch] = eff; m_rem[ch] = eff; m_tick[ch] = 1'b0;
            end else if (enable) begin
                if (m_rem[ch] == 1) begin
                    m_tick[ch] = 1'b1; m_sq[ch] = ~m_sq[ch]; m_rem[ch] = m_div[ch];
                end else begin
                    m_rem[ch] = m_rem[ch] - 1; m_tick[ch] = 1'b0;
                end
            end else begin
                m_tick[ch] = 1'b0;
            end
        end
        e.tick = m_tick;
        e.sq   = m_sq;
        exp_q.push_back(e);
    endtask

    // One clock: predict, let the edge happen, then pop and compare on the falling edge.
    task automatic cyc();
        exp_t e;
        model_step();
        @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        if (exp_q.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq("tick", 32'(tick), 32'(e.tick));
            check_eq("sq_out", 32'(sq_out), 32'(e.sq));
        end
        for (int ch = 0; ch < NCH; ch++) if (tick[ch]) hits[ch]++;
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) cyc();
    endtask

    task automatic wr_div(input int unsigned sel, input int unsigned val);
        div_wr = 1'b1; div_sel = SW'(sel); div_val = CW'(val);
        cyc();
        div_wr = 1'b0;
    endtask

    initial begin
        int unsigned base [NCH];
        for (int ch = 0; ch < NCH; ch++) hits[ch] = 0;
        @(negedge clk_100MHz);
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        check_eq("reset_tick", 32'(tick), 32'd0);
        check_eq("reset_sq", 32'(sq_out), 32'd0);

        // Divisor 5 on channel 0: six ticks in 30 enabled cycles.
        wr_div(0, 5);
        enable = 1'b1;
        base[0] = hits[0];
        run(30);
        check_eq("ch0_ticks_30", hits[0] - base[0], 32'd6);

        // Enable gating mid-count on channel 1.
        wr_div(1, 3);
        run(1);
        enable = 1'b0;
        run(4);
        enable = 1'b1;
        base[1] = hits[1];
        run(2);
        check_eq("ch1_resume_tick", 32'(tick[1]), 32'd1);
        check_eq("ch1_resume_cnt", hits[1] - base[1], 32'd1);
        run(4);

        // Divisor 0 then 1 on channel 2: tick held high.
        wr_div(2, 0);
        run(6);
        wr_div(2, 1);
        run(6);

        // Lowering channel 3's divisor mid-count restarts the count.
        wr_div(3, 8);
        run(6);
        wr_div(3, 4);
        base[3] = hits[3];
        run(4);
        check_eq("ch3_after_lower", hits[3] - base[3], 32'd1);
        run(6);

        // sync_clr with all channels at 3/5/7/9.
        enable = 1'b0;
        wr_div(0, 3); wr_div(1, 5); wr_div(2, 7); wr_div(3, 9);
        enable = 1'b1;
        run(4);
        sync_clr = 1'b1;
        cyc();
        sync_clr = 1'b0;
        check_eq("clr_tick", 32'(tick), 32'd0);
        check_eq("clr_sq", 32'(sq_out), 32'd0);
        for (int ch = 0; ch < NCH; ch++) base[ch] = hits[ch];
        run(9);
        check_eq("clr_hits0", hits[0] - base[0], 32'd3);
        check_eq("clr_hits1", hits[1] - base[1], 32'd1);
        check_eq("clr_hits2", hits[2] - base[2], 32'd1);
        check_eq("clr_hits3", hits[3] - base[3], 32'd1);

        // sync_clr while disabled, and combined with a divisor write.
        enable = 1'b0;
        sync_clr = 1'b1; div_wr = 1'b1; div_sel = SW'(2); div_val = CW'(2);
        cyc();
        sync_clr = 1'b0; div_wr = 1'b0;
        enable = 1'b1;
        run(8);

        // Out-of-range select is ignored; reset mid-count restores defaults.
        wr_div(5, 2);
        run(7);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int ch = 0; ch < NCH; ch++) base[ch] = hits[ch];
        run(9);
        check_eq("rst_no_early", 32'(tick), 32'd0);
        run(1);
        for (int ch = 0; ch < NCH; ch++)
            check_eq("rst_first_tick", hits[ch] - base[ch], 32'd1);
        run(12);

        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_multi_channel_tick_generator
